logs_sweep_ctrl: RTL and testbench
==================================

LOGS_SWEEP_CTRL -- requirements
Module: logs_sweep_ctrl

Interface
REQ-001 SHALL have parameter FRAC, default 8: fractional bits of x and r.
REQ-002 SHALL have parameter N_OSC, default 4: number of voice frequency slots loaded per r step.
REQ-003 SHALL have parameter SETTLE_ITERS, default 64: map iterations discarded after each r change (>=1).
REQ-004 SHALL have parameter DWELL, default 30000: idle clocks held per r step (>=1).
REQ-005 SHALL have parameters R_START, R_STEP and R_END, defaults 0x110, 0x001 and 0x3FF: r sweep bounds and increment, 2.FRAC fixed-point.
REQ-006 SHALL have parameter LOOP, default 1: 1 = restart the sweep at R_START after R_END; 0 = stop.
REQ-007 SHALL have port clk, input, 1 bit: the only clock; all logic rises on posedge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: begin a sweep; sampled only in IDLE.
REQ-010 SHALL have port stop, input, 1 bit: abort the sweep; sampled in every state.
REQ-011 SHALL have port x_in, input, FRAC bits: current x from the map iterator.
REQ-012 SHALL have port r_out, output, FRAC+2 bits: registered r driven to the map iterator.
REQ-013 SHALL have port x_load, output, 1 bit: one-cycle pulse that reseeds x to 0.0625.
REQ-014 SHALL have port iter_en, output, 1 bit: the map advances on each cycle it is high.
REQ-015 SHALL have port voice_we, voice_idx and voice_data, outputs of 1, $clog2(N_OSC) and FRAC bits: voice slot write strobe, slot index and data.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a sweep when LOOP=0.

Function
REQ-018 SHALL implement states IDLE, SEED, SETTLE, CAPTURE, DWELL and STEP, with all outputs decoded from registered state and counters.
REQ-019 SHALL move IDLE->SEED on the cycle after start=1 is sampled with stop=0.
REQ-020 SHALL hold SEED for 1 cycle: x_load=1, iter_en=0; next state SETTLE.
REQ-021 SHALL hold SETTLE for exactly SETTLE_ITERS cycles: iter_en=1, voice_we=0; next state CAPTURE.
REQ-022 SHALL hold CAPTURE for exactly N_OSC cycles: iter_en=1, voice_we=1; voice_idx = 0..N_OSC-1 ascending, one per cycle; voice_data = x_in combinationally in the same cycle.
REQ-023 SHALL hold DWELL for exactly DWELL cycles: iter_en=0, voice_we=0; next state STEP.
REQ-024 SHALL hold STEP for 1 cycle; let n = r_out + R_STEP computed at FRAC+3 bits (no wrap).
REQ-025 SHALL, in STEP, if n <= R_END: set r_out <= n and go to SETTLE without reseeding.
REQ-026 SHALL, in STEP, if n > R_END and LOOP=1: set r_out <= R_START and go to SEED.
REQ-027 SHALL, in STEP, if n > R_END and LOOP=0: set r_out <= R_START, go to IDLE, and assert done=1 in the first IDLE cycle only.
REQ-028 SHALL change r_out only in STEP, on reset, or on stop.
REQ-029 SHALL, on stop=1 in any non-IDLE state, enter IDLE the next cycle with r_out <= R_START, all strobes 0 and done=0.
REQ-030 SHALL, when start and stop are both 1 in IDLE, stay in IDLE (stop wins).
REQ-031 SHALL ignore start outside IDLE.
REQ-032 SHALL size the counters to max(SETTLE_ITERS, DWELL, N_OSC) with no overflow; N_OSC=1 SHALL yield a 1-bit voice_idx held at 0.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, give the following on the next cycle: state IDLE, r_out=R_START, x_load=iter_en=voice_we=busy=done=0, voice_idx=0, all counters 0.
REQ-034 SHALL give reset priority over start and stop in every state, including mid-CAPTURE, where the write stops immediately.

Verification (FRAC=8, N_OSC=4, SETTLE_ITERS=3, DWELL=5, R_START=0x110, R_STEP=0x40, R_END=0x190, LOOP=0 unless stated)
REQ-035 SHALL cover: start pulse at cycle 0 -> x_load=1 at cycle 1; iter_en=1 at cycles 2-8; voice_we=1 at cycles 5-8 with idx 0,1,2,3; voice_data tracks x_in.
REQ-036 SHALL cover: full sweep -> r_out steps 0x110, 0x150, 0x190; the next STEP goes to IDLE with r_out=0x110 and a single done pulse; busy falls together with the done pulse.
REQ-037 SHALL cover: LOOP=1, same stimulus -> after r_out=0x190 the next STEP gives r_out=0x110, a new SEED (x_load pulse) follows, done is never asserted, and busy stays 1.
REQ-038 SHALL cover: stop during CAPTURE at idx=2 -> next cycle IDLE, voice_we=0, r_out=0x110, busy=0, no slot-3 write.
REQ-039 SHALL cover: start=stop=1 in IDLE -> stays IDLE; start during DWELL -> no effect, DWELL length unchanged at 5.
REQ-040 SHALL cover: reset asserted mid-SETTLE -> the REQ-033 values on the next cycle; a later start produces timing identical to REQ-035.

Source files
------------

// File: rtl/logs_sweep_ctrl.sv
// Sequencer that sweeps the logistic-map parameter r across a range.
// Each step lets the map settle, captures N_OSC voice values, then dwells before stepping r.
module logs_sweep_ctrl #(
    parameter int          FRAC         = 8,
    parameter int          N_OSC        = 4,
    parameter int          SETTLE_ITERS = 64,
    parameter int          DWELL        = 30000,
    parameter int unsigned R_START      = 32'h110,
    parameter int unsigned R_STEP       = 32'h001,
    parameter int unsigned R_END        = 32'h3FF,
    parameter int          LOOP         = 1,
    localparam int         IW           = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic [FRAC-1:0] x_in,
    output logic [FRAC+1:0] r_out,
    output logic            x_load,
    output logic            iter_en,
    output logic            voice_we,
    output logic [IW-1:0]   voice_idx,
    output logic [FRAC-1:0] voice_data,
    output logic            busy,
    output logic            done
);

    localparam int CMAX_A = (SETTLE_ITERS > DWELL) ? SETTLE_ITERS : DWELL;
    localparam int CMAX   = (CMAX_A > N_OSC) ? CMAX_A : N_OSC;
    localparam int CW     = $clog2(CMAX + 1);

    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_ITERS - 1);
    localparam logic [CW-1:0]   CAPTURE_LAST = CW'(N_OSC - 1);
    localparam logic [CW-1:0]   DWELL_LAST  = CW'(DWELL - 1);
    localparam logic [FRAC+1:0] START_W     = (FRAC+2)'(R_START);
    localparam logic [FRAC+2:0] STEP_W      = (FRAC+3)'(R_STEP);
    localparam logic [FRAC+2:0] END_W       = (FRAC+3)'(R_END);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_SETTLE,
        S_CAPTURE,
        S_DWELL,
        S_STEP
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [FRAC+1:0] r_next;
    logic            done_reg, done_next;
    logic [FRAC+2:0] r_sum;

    // One extra bit so the end-of-sweep comparison never sees a wrapped value
    assign r_sum = {1'b0, r_out} + STEP_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            r_out    <= START_W;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            r_out    <= r_next;
            done_reg <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        r_next     = r_out;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (start && !stop) state_next = S_SEED;
            end
            S_SEED: begin
                cnt_next   = '0;
                state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = S_CAPTURE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_CAPTURE: begin
                if (cnt == CAPTURE_LAST) begin
                    cnt_next   = '0;
                    state_next = S_DWELL;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_DWELL: begin
                if (cnt == DWELL_LAST) begin
                    cnt_next   = '0;
                    state_next = S_STEP;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_STEP: begin
                cnt_next = '0;
                if (r_sum <= END_W) begin
                    r_next     = r_sum[FRAC+1:0];
                    state_next = S_SETTLE;
                end else begin
                    r_next = START_W;
                    if (LOOP != 0) begin
                        state_next = S_SEED;
                    end else begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
        // Abort overrides whatever the active state decided
        if (stop && state != S_IDLE) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            r_next     = START_W;
            done_next  = 1'b0;
        end
    end

    assign x_load     = (state == S_SEED);
    assign iter_en    = (state == S_SETTLE) || (state == S_CAPTURE);
    assign voice_we   = (state == S_CAPTURE);
    assign voice_idx  = voice_we ? cnt[IW-1:0] : '0;
    assign voice_data = voice_we ? x_in : '0;
    assign busy       = (state != S_IDLE);
    assign done       = done_reg;

endmodule

// File: tb/tb_logs_sweep_ctrl.sv
// Directed bench for logs_sweep_ctrl: a one-shot instance and a looping instance share stimulus.
module tb_logs_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic [7:0] x_in;

    logic [9:0] r_out0, r_out1;
    logic       x_load0, x_load1, iter_en0, iter_en1, voice_we0, voice_we1;
    logic [1:0] voice_idx0, voice_idx1;
    logic [7:0] voice_data0, voice_data1;
    logic       busy0, busy1, done0, done1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       xl;
        logic       ie;
        logic       we;
        logic [1:0] idx;
        logic [9:0] r;
    } vec_t;

    vec_t tbl[1:15];

    logs_sweep_ctrl #(
        .FRAC(8), .N_OSC(4), .SETTLE_ITERS(3), .DWELL(5),
        .R_START(32'h110), .R_STEP(32'h40), .R_END(32'h190), .LOOP(0)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .x_in(x_in),
        .r_out(r_out0), .x_load(x_load0), .iter_en(iter_en0), .voice_we(voice_we0),
        .voice_idx(voice_idx0), .voice_data(voice_data0), .busy(busy0), .done(done0)
    );

    logs_sweep_ctrl #(
        .FRAC(8), .N_OSC(4), .SETTLE_ITERS(3), .DWELL(5),
        .R_START(32'h110), .R_STEP(32'h40), .R_END(32'h190), .LOOP(1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .x_in(x_in),
        .r_out(r_out1), .x_load(x_load1), .iter_en(iter_en1), .voice_we(voice_we1),
        .voice_idx(voice_idx1), .voice_data(voice_data1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic xl, logic ie, logic we, logic [1:0] idx, logic [9:0] r);
        vec_t v;
        v.xl  = xl;
        v.ie  = ie;
        v.we  = we;
        v.idx = idx;
        v.r   = r;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock, then present the x value for cycle c
    task automatic apply_stimulus(input int c);
        @(posedge clk);
        #1;
        x_in = 8'(32 + c * 7);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, " x_load"},   32'(x_load0),   32'd0);
        check_output({tag, " iter_en"},  32'(iter_en0),  32'd0);
        check_output({tag, " voice_we"}, 32'(voice_we0), 32'd0);
        check_output({tag, " idx"},      32'(voice_idx0), 32'd0);
        check_output({tag, " busy"},     32'(busy0),     32'd0);
        check_output({tag, " done"},     32'(done0),     32'd0);
        check_output({tag, " r_out"},    32'(r_out0),    32'h110);
        check_output({tag, " busy1"},    32'(busy1),     32'd0);
        check_output({tag, " r_out1"},   32'(r_out1),    32'h110);
    endtask

    // Start pulse, then walk cycles 1..15 against the table
    task automatic run_start_table(input string tag);
        start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            apply_stimulus(c);
            start = 1'b0;
            check_output($sformatf("%s c%0d x_load", tag, c),  32'(x_load0),   32'(tbl[c].xl));
            check_output($sformatf("%s c%0d iter_en", tag, c), 32'(iter_en0),  32'(tbl[c].ie));
            check_output($sformatf("%s c%0d we", tag, c),      32'(voice_we0), 32'(tbl[c].we));
            check_output($sformatf("%s c%0d idx", tag, c),     32'(voice_idx0), 32'(tbl[c].idx));
            check_output($sformatf("%s c%0d r_out", tag, c),   32'(r_out0),    32'(tbl[c].r));
            check_output($sformatf("%s c%0d busy", tag, c),    32'(busy0),     32'd1);
            check_output($sformatf("%s c%0d done", tag, c),    32'(done0),     32'd0);
            if (tbl[c].we)
                check_output($sformatf("%s c%0d vdata", tag, c), 32'(voice_data0), 32'(8'(32 + c * 7)));
        end
    endtask

    initial begin
        int done0_cnt;
        int done1_cnt;

        tbl[1] = mk(1, 0, 0, 0, 10'h110);
        for (int c = 2; c <= 4; c++)  tbl[c] = mk(0, 1, 0, 0, 10'h110);
        for (int c = 5; c <= 8; c++)  tbl[c] = mk(0, 1, 1, 2'(c - 5), 10'h110);
        for (int c = 9; c <= 14; c++) tbl[c] = mk(0, 0, 0, 0, 10'h110);
        tbl[15] = mk(0, 1, 0, 0, 10'h150);

        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        x_in  = 8'h00;
        apply_stimulus(0);
        apply_stimulus(0);
        reset = 1'b0;
        check_reset_state("reset");

        // Full sweep with done pulse on the one-shot instance and wrap on the looping one
        done0_cnt = 0;
        done1_cnt = 0;
        run_start_table("first");
        for (int c = 16; c <= 45; c++) begin
            apply_stimulus(c);
            done0_cnt += int'(done0);
            done1_cnt += int'(done1);
            if (c == 27) check_output("sweep c27 r_out", 32'(r_out0), 32'h150);
            if (c == 28) check_output("sweep c28 r_out", 32'(r_out0), 32'h190);
            if (c == 40) begin
                check_output("sweep c40 r_out", 32'(r_out0), 32'h190);
                check_output("sweep c40 busy",  32'(busy0),  32'd1);
                check_output("sweep c40 done",  32'(done0),  32'd0);
            end
            if (c == 41) begin
                check_output("sweep c41 done",    32'(done0),   32'd1);
                check_output("sweep c41 busy",    32'(busy0),   32'd0);
                check_output("sweep c41 r_out",   32'(r_out0),  32'h110);
                check_output("loop c41 x_load",   32'(x_load1), 32'd1);
                check_output("loop c41 busy",     32'(busy1),   32'd1);
                check_output("loop c41 r_out",    32'(r_out1),  32'h110);
            end
            if (c == 42) check_output("sweep c42 done", 32'(done0), 32'd0);
            if (c == 45) begin
                check_output("loop c45 we",   32'(voice_we1), 32'd1);
                check_output("loop c45 busy", 32'(busy1),     32'd1);
            end
        end
        check_output("sweep done pulses", 32'(done0_cnt), 32'd1);
        check_output("loop done pulses",  32'(done1_cnt), 32'd0);

        stop = 1'b1;
        apply_stimulus(0);
        stop = 1'b0;
        check_output("loop stopped busy", 32'(busy1), 32'd0);
        check_output("loop stopped done", 32'(done1), 32'd0);

        // Stop mid-CAPTURE at idx 2
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            apply_stimulus(c);
            start = 1'b0;
        end
        check_output("stop pre idx", 32'(voice_idx0), 32'd2);
        check_output("stop pre we",  32'(voice_we0),  32'd1);
        stop = 1'b1;
        apply_stimulus(8);
        stop = 1'b0;
        check_output("stop we",    32'(voice_we0),  32'd0);
        check_output("stop busy",  32'(busy0),      32'd0);
        check_output("stop r_out", 32'(r_out0),     32'h110);
        check_output("stop idx",   32'(voice_idx0), 32'd0);
        check_output("stop done",  32'(done0),      32'd0);
        apply_stimulus(9);
        check_output("stop after we",   32'(voice_we0), 32'd0);
        check_output("stop after busy", 32'(busy0),     32'd0);

        // Start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        apply_stimulus(0);
        start = 1'b0;
        stop  = 1'b0;
        check_output("start+stop busy",   32'(busy0),   32'd0);
        check_output("start+stop x_load", 32'(x_load0), 32'd0);
        apply_stimulus(0);
        check_output("start+stop later busy", 32'(busy0), 32'd0);

        // Start during DWELL must not alter its length
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            apply_stimulus(c);
            start = 1'b0;
        end
        start = 1'b1;
        apply_stimulus(10);
        apply_stimulus(11);
        start = 1'b0;
        for (int c = 12; c <= 15; c++) begin
            apply_stimulus(c);
            if (c <= 14) check_output($sformatf("dwell c%0d iter_en", c), 32'(iter_en0), 32'd0);
            if (c <= 14) check_output($sformatf("dwell c%0d x_load", c),  32'(x_load0),  32'd0);
        end
        check_output("dwell c15 iter_en", 32'(iter_en0), 32'd1);
        check_output("dwell c15 r_out",   32'(r_out0),   32'h150);
        stop = 1'b1;
        apply_stimulus(0);
        stop = 1'b0;

        // Reset mid-SETTLE, then a clean restart
        start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            apply_stimulus(c);
            start = 1'b0;
        end
        check_output("pre-reset iter_en", 32'(iter_en0), 32'd1);
        reset = 1'b1;
        apply_stimulus(0);
        reset = 1'b0;
        check_reset_state("midreset");
        run_start_table("restart");

        stop = 1'b1;
        apply_stimulus(0);
        stop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
